// File: rtl/sdram_wb_arb_if.sv
// Wishbone classic bus bundle shared by the arbiter's master ports
// and its single SDRAM-side slave connection.
interface sdram_wb_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err
  );
endinterface

// File: rtl/sdram_wb_arb.sv
// Three-port Wishbone arbiter in front of the SDRAM controller slave:
// round-robin / fixed priority, drain on abandon, watchdog timeout.
module sdram_wb_arb #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int TMO_W = 10
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  sdram_wb_arb_if.slave    m0,
  sdram_wb_arb_if.slave    m1,
  sdram_wb_arb_if.slave    m2,
  sdram_wb_arb_if.master   s,
  input  logic             cfg_arb_mode,
  input  logic [TMO_W-1:0] cfg_tmo,
  output logic [1:0]       arb_gnt,
  output logic             arb_busy,
  output logic             tmo_evt
);

  localparam int RW = 1 + AW + DW + DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       last_q;
  logic [TMO_W-1:0] cnt_q;
  logic             cyc_q;
  logic             stb_q;
  logic [RW-1:0]    bus_q;

  logic [3:0]       req;
  logic [3:0]       cyc_v;
  logic [1:0]       win;
  logic [1:0]       nx1;
  logic [1:0]       nx2;
  logic [RW-1:0]    win_bus;
  logic             grant;
  logic             done;
  logic             tmo_hit;
  logic             gnt_cyc;
  logic [3:0]       ack_v;
  logic [3:0]       err_v;

  assign req = {1'b0,
                m2.cyc & m2.stb,
                m1.cyc & m1.stb,
                m0.cyc & m0.stb};

  assign cyc_v = {1'b0, m2.cyc, m1.cyc, m0.cyc};

  assign gnt_cyc = cyc_v[last_q];
  assign tmo_hit = (cfg_tmo != '0) && (cnt_q == cfg_tmo);

  // Rotation starts one past the last grant and wraps over 0..2.
  assign nx1 = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
  assign nx2 = (nx1 == 2'd2) ? 2'd0 : nx1 + 2'd1;

  always_comb begin
    win = last_q;
    if (cfg_arb_mode) begin
      if (req[0])      win = 2'd0;
      else if (req[1]) win = 2'd1;
      else             win = 2'd2;
    end else begin
      if (req[nx1])      win = nx1;
      else if (req[nx2]) win = nx2;
      else               win = last_q;
    end
  end

  always_comb begin
    unique case (win)
      2'd0:    win_bus = {m0.we, m0.adr, m0.dat_w, m0.sel};
      2'd1:    win_bus = {m1.we, m1.adr, m1.dat_w, m1.sel};
      default: win_bus = {m2.we, m2.adr, m2.dat_w, m2.sel};
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    done    = 1'b0;
    ack_v   = '0;
    err_v   = '0;
    tmo_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (s.ack) begin
          ack_v[last_q] = 1'b1;
          done          = 1'b1;
          state_d       = IDLE;
        end else if (tmo_hit) begin
          err_v[last_q] = 1'b1;
          tmo_evt       = 1'b1;
          done          = 1'b1;
          state_d       = IDLE;
        end else if (!gnt_cyc) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (s.ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          tmo_evt = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_q <= win;
        cyc_q  <= 1'b1;
        stb_q  <= 1'b1;
        bus_q  <= win_bus;
        cnt_q  <= '0;
      end else if (done) begin
        cyc_q  <= 1'b0;
        stb_q  <= 1'b0;
      end
      // Saturate so a disabled or huge limit never wraps into a match.
      if (state_q != IDLE && cnt_q != '1)
        cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  assign s.cyc = cyc_q;
  assign s.stb = stb_q;
  assign {s.we, s.adr, s.dat_w, s.sel} = bus_q;

  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m2.dat_r = s.dat_r;
  assign m0.ack   = ack_v[0];
  assign m1.ack   = ack_v[1];
  assign m2.ack   = ack_v[2];
  assign m0.err   = err_v[0];
  assign m1.err   = err_v[1];
  assign m2.err   = err_v[2];

  assign arb_gnt  = last_q;
  assign arb_busy = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_wb_arb.sv
// Randomized bench for sdram_wb_arb against a transaction-level
// model of grant order, drain and watchdog behaviour.
module tb_sdram_wb_arb;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TMO_W = 10;
  localparam int RW    = 1 + AW + DW + DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_wb_arb_if #(.AW(AW), .DW(DW)) m0_bus ();
  sdram_wb_arb_if #(.AW(AW), .DW(DW)) m1_bus ();
  sdram_wb_arb_if #(.AW(AW), .DW(DW)) m2_bus ();
  sdram_wb_arb_if #(.AW(AW), .DW(DW)) s_bus ();

  logic             cfg_arb_mode = 1'b0;
  logic [TMO_W-1:0] cfg_tmo = '0;
  logic [1:0]       arb_gnt;
  logic             arb_busy;
  logic             tmo_evt;

  sdram_wb_arb #(.AW(AW), .DW(DW), .TMO_W(TMO_W)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .m0           (m0_bus),
    .m1           (m1_bus),
    .m2           (m2_bus),
    .s            (s_bus),
    .cfg_arb_mode (cfg_arb_mode),
    .cfg_tmo      (cfg_tmo),
    .arb_gnt      (arb_gnt),
    .arb_busy     (arb_busy),
    .tmo_evt      (tmo_evt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // stimulus knobs
  bit               mcyc [3];
  bit               mwe  [3];
  logic [AW-1:0]    madr [3];
  logic [DW-1:0]    mdat [3];
  logic [DW/8-1:0]  msel [3];
  int               mgap [3];
  bit [2:0]         mask = '0;
  bit [2:0]         ab_mask = '0;
  int               ab_rate = 2;
  int               gapmax = 0;
  int               dmin = 0;
  int               dmax = 0;
  bit               noack = 0;
  bit               stray_en = 0;
  bit               force_ack = 0;
  bit               rst_req = 1;
  bit               chk_en = 0;
  bit               chk_zero = 0;
  bit               nxt_mode = 0;
  logic [TMO_W-1:0] nxt_tmo = '0;

  // reference model
  bit               m_busy = 0;
  bit               m_drain = 0;
  int               m_gnt = 0;
  int               m_last = 2;
  int               m_cnt = 0;
  logic [RW-1:0]    m_bus = '0;
  int               glog [$];
  int               drains = 0;
  int               tmos = 0;
  int               err_cnt = 0;

  int               sl_cnt = 0;
  int               sl_dly = 0;
  int               stb_run = 0;
  logic             s_ack = 1'b0;

  task automatic drive();
    m0_bus.cyc = mcyc[0]; m0_bus.stb = mcyc[0];
    m0_bus.we = mwe[0]; m0_bus.adr = madr[0];
    m0_bus.dat_w = mdat[0]; m0_bus.sel = msel[0];
    m1_bus.cyc = mcyc[1]; m1_bus.stb = mcyc[1];
    m1_bus.we = mwe[1]; m1_bus.adr = madr[1];
    m1_bus.dat_w = mdat[1]; m1_bus.sel = msel[1];
    m2_bus.cyc = mcyc[2]; m2_bus.stb = mcyc[2];
    m2_bus.we = mwe[2]; m2_bus.adr = madr[2];
    m2_bus.dat_w = mdat[2]; m2_bus.sel = msel[2];
    rst = rst_req;
  endtask

  task automatic new_req(input int n);
    mcyc[n] = 1'b1;
    mwe[n]  = 1'($urandom_range(0, 1));
    madr[n] = $urandom;
    mdat[n] = $urandom;
    msel[n] = 4'($urandom_range(1, 15));
  endtask

  task automatic tick();
    logic [2:0] ack_o;
    logic [2:0] err_o;
    logic [2:0] e_ack;
    logic [2:0] e_err;
    bit         tmo_now;
    @(negedge clk);
    cfg_arb_mode = nxt_mode;
    cfg_tmo      = nxt_tmo;
    if (s_bus.stb) begin
      if (sl_cnt == 0) sl_dly = $urandom_range(dmin, dmax);
      s_ack = !noack && (sl_cnt >= sl_dly);
      sl_cnt++;
      stb_run++;
    end else begin
      sl_cnt  = 0;
      stb_run = 0;
      s_ack   = force_ack || (stray_en && $urandom_range(0, 7) == 0);
    end
    force_ack     = 0;
    s_bus.ack     = s_ack;
    s_bus.dat_r   = $urandom;
    #1;
    ack_o = {m2_bus.ack, m1_bus.ack, m0_bus.ack};
    err_o = {m2_bus.err, m1_bus.err, m0_bus.err};
    if (|err_o) err_cnt++;
    tmo_now = m_busy && cfg_tmo != 0 && m_cnt == int'(cfg_tmo);
    if (chk_en) begin
      e_ack = '0;
      e_err = '0;
      if (m_busy && !m_drain && s_ack) e_ack[m_gnt] = 1'b1;
      if (m_busy && !m_drain && tmo_now && !s_ack) e_err[m_gnt] = 1'b1;
      if (tmo_now && !s_ack) tmos++;
      chk("ctl",
          {s_bus.cyc, s_bus.stb, arb_busy, arb_gnt, ack_o, err_o, tmo_evt},
          {m_busy, m_busy, m_busy, 2'(m_last), e_ack, e_err,
           tmo_now && !s_ack});
      if (m_busy)
        chk("bus", {s_bus.we, s_bus.adr, s_bus.dat_w, s_bus.sel}, m_bus);
      if (s_ack)
        chk("rdata", {m0_bus.dat_r, m1_bus.dat_r, m2_bus.dat_r},
            {3{s_bus.dat_r}});
      if (chk_zero)
        chk("rst_bus", {s_bus.we, s_bus.adr, s_bus.dat_w, s_bus.sel}, '0);
      if (tmo_evt)
        chk("tmo_lat", stb_run, int'(cfg_tmo) + 1);
    end
    chk_zero = 0;
    for (int n = 0; n < 3; n++) begin
      if (mcyc[n] && (ack_o[n] || err_o[n])) begin
        mcyc[n] = 1'b0;
        mgap[n] = $urandom_range(0, gapmax);
      end else if (mcyc[n] && ab_mask[n] && m_busy && !m_drain &&
                   m_gnt == n && !s_ack &&
                   $urandom_range(0, ab_rate - 1) == 0) begin
        mcyc[n] = 1'b0;
        mgap[n] = $urandom_range(1, gapmax + 1);
      end
      if (!mcyc[n] && mask[n]) begin
        if (mgap[n] == 0) new_req(n);
        else mgap[n]--;
      end
    end
    if (rst_req) begin
      m_busy  = 0;
      m_drain = 0;
      m_last  = 2;
      m_cnt   = 0;
    end else if (!m_busy) begin
      int w;
      w = -1;
      if (cfg_arb_mode) begin
        for (int n = 2; n >= 0; n--) if (mcyc[n]) w = n;
      end else begin
        for (int k = 3; k >= 1; k--)
          if (mcyc[(m_last + k) % 3]) w = (m_last + k) % 3;
      end
      if (w >= 0) begin
        m_busy  = 1;
        m_drain = 0;
        m_gnt   = w;
        m_last  = w;
        m_cnt   = 0;
        m_bus   = {mwe[w], madr[w], mdat[w], msel[w]};
        glog.push_back(w);
      end
    end else begin
      if (s_ack || tmo_now) begin
        m_busy = 0;
      end else begin
        if (!m_drain && !mcyc[m_gnt]) begin
          m_drain = 1;
          drains++;
        end
        if (m_cnt < 1023) m_cnt++;
      end
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic settle();
    mask  = '0;
    noack = 0;
    for (int i = 0; i < 300 &&
         (m_busy || mcyc[0] || mcyc[1] || mcyc[2]); i++)
      tick();
    chk("settle", {m_busy, mcyc[0], mcyc[1], mcyc[2]}, '0);
  endtask

  task automatic do_reset();
    rst_req = 1;
    tick();
    rst_req  = 0;
    chk_zero = 1;
  endtask

  initial begin
    for (int n = 0; n < 3; n++) begin
      madr[n] = '0;
      mdat[n] = '0;
      msel[n] = '0;
      mgap[n] = 0;
    end
    s_bus.ack   = 1'b0;
    s_bus.err   = 1'b0;
    s_bus.dat_r = '0;
    drive();
    tick();
    chk_en = 1;
    do_reset();

    // single master write, slave acks after 4 wait cycles
    dmin = 4; dmax = 4;
    mcyc[0] = 1'b1; mwe[0] = 1'b1;
    madr[0] = 32'h0000_0100; mdat[0] = 32'hA5A5_5A5A; msel[0] = 4'hF;
    run(12);
    chk("single_gnt", glog.size(), 1);
    settle();

    // round-robin with everyone requesting continuously
    dmin = 0; dmax = 3; gapmax = 0; mask = 3'b111;
    do_reset();
    glog.delete();
    run(60);
    chk("rr_len", glog.size() >= 9, 1);
    for (int i = 0; i < 9 && i < glog.size(); i++)
      chk("rr_gnt", glog[i], i % 3);
    settle();

    // fixed priority: m0 starves m2 until it stops
    nxt_mode = 1; gapmax = 0; mask = 3'b101;
    glog.delete();
    run(40);
    chk("fp_len", glog.size() > 2, 1);
    foreach (glog[i]) chk("fp_m0", glog[i], 0);
    glog.delete();
    mask = 3'b100;
    run(20);
    if (glog.size() > 0) chk("fp_m2", glog[glog.size() - 1], 2);
    else chk("fp_m2_len", glog.size(), 1);
    settle();

    // abandoned cycles drain without any master ack
    nxt_mode = 0; dmin = 5; dmax = 5; gapmax = 2;
    mask = 3'b010; ab_mask = 3'b010; ab_rate = 2;
    drains = 0;
    run(80);
    chk("drain_seen", drains > 0, 1);
    ab_mask = '0;
    run(20);
    settle();

    // watchdog with limit 10, slave never acks
    nxt_tmo = 10; noack = 1; mask = 3'b100; gapmax = 3;
    tmos = 0;
    run(40);
    chk("tmo_seen", tmos > 0, 1);
    settle();

    // watchdog disabled: a stuck cycle never errors
    nxt_tmo = 0;
    run(2);
    noack = 1; mask = 3'b100;
    err_cnt = 0;
    run(2000);
    chk("no_tmo", err_cnt, 0);
    settle();

    // random traffic
    mask = 3'b111; ab_mask = 3'b111; ab_rate = 16;
    dmin = 0; dmax = 10; stray_en = 1; gapmax = 3;
    for (int p = 0; p < 12; p++) begin
      nxt_mode = 1'($urandom_range(0, 1));
      nxt_tmo  = TMO_W'($urandom_range(0, 8));
      run(50);
    end
    ab_mask = '0; stray_en = 0; nxt_tmo = 0;
    settle();

    // reset mid-transaction, late ack ignored, m0 wins first
    noack = 1; mask = 3'b001;
    for (int i = 0; i < 10 && !m_busy; i++) tick();
    run(2);
    chk("pre_rst_busy", m_busy, 1);
    mask = 3'b111; noack = 0;
    do_reset();
    force_ack = 1;
    glog.delete();
    run(30);
    chk("rst_first", glog.size() > 0 ? glog[0] : -1, 0);
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_wb_arb.md
# sdram_wb_arb

Three-port Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller top among three requesters: m0 = CPU data, m1 = CPU instruction, m2 = DMA. It sits between the core bus fabric and the SDRAM controller's WB slave. It provides:
- round-robin or fixed-priority grant;
- single-transaction locking until ack;
- controlled drain when a master abandons a cycle;
- a programmable watchdog that errors out a transaction which never gets an ack.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; select width is DW/8
- TMO_W, 10, watchdog counter width

Ports:
- wb_clk_i  in  1  WB clock; all logic on rising edge
- wb_rst_i  in  1  reset; synchronous, active-high
- mN_wb_cyc_i / mN_wb_stb_i / mN_wb_we_i  in  1 each  master N (N = 0..2) cycle, strobe, write
- mN_wb_adr_i  in  AW  master N address
- mN_wb_dat_i  in  DW  master N write data
- mN_wb_sel_i  in  DW/8  master N byte select
- mN_wb_dat_o  out  DW  read data to master N
- mN_wb_ack_o / mN_wb_err_o  out  1 each  ack / error to master N
- s_wb_cyc_o / s_wb_stb_o / s_wb_we_o  out  1 each  to SDRAM WB slave
- s_wb_adr_o  out  AW  to SDRAM WB slave
- s_wb_dat_o  out  DW  to SDRAM WB slave
- s_wb_sel_o  out  DW/8  to SDRAM WB slave
- s_wb_dat_i  in  DW  read data from SDRAM WB slave
- s_wb_ack_i  in  1  ack from SDRAM WB slave
- cfg_arb_mode  in  1  0 = round-robin, 1 = fixed priority m0 > m1 > m2
- cfg_tmo  in  TMO_W  watchdog limit in cycles; 0 disables the watchdog
- arb_gnt  out  2  current/last grant index (0..2)
- arb_busy  out  1  high in BUSY or DRAIN
- tmo_evt  out  1  one-cycle pulse on watchdog expiry

## Operation
- Request: master N requests when mN_wb_cyc_i & mN_wb_stb_i.
- FSM states: IDLE, BUSY, DRAIN.
- IDLE:
  - If any request: pick a winner, register the grant, latch the winner's we/adr/dat/sel into the slave output registers, assert s_wb_cyc_o/s_wb_stb_o, clear the watchdog counter, go to BUSY.
  - Otherwise stay in IDLE with slave cyc/stb low.
- Round-robin: search order starts at (last_gnt+1) mod 3 and wraps. last_gnt resets to 2, so m0 wins first.
- Fixed priority: lowest requesting index wins. last_gnt is still updated.
- BUSY:
  - Slave outputs are held constant. Master inputs are not re-sampled; masters must hold them until ack.
  - s_wb_ack_i=1: pass the ack to the granted master in the same cycle (combinational); mN_wb_dat_o = s_wb_dat_i for all N. Drop cyc/stb on the next edge and go to IDLE.
  - Granted master drops cyc before ack: go to DRAIN. Slave cyc/stb stay high.
  - Watchdog: counter increments each BUSY cycle. When counter == cfg_tmo (cfg_tmo≠0) and no ack in that cycle:
    - mN_wb_err_o=1 for one cycle to the granted master;
    - tmo_evt pulses;
    - slave cyc/stb drop on the next edge; go to IDLE.
- DRAIN:
  - Hold slave outputs until s_wb_ack_i, then go to IDLE. The ack is not forwarded to any master.
  - The watchdog still applies, with no err_o; tmo_evt still pulses.
- A stray s_wb_ack_i in IDLE is ignored.
- Ack has priority over timeout in the same cycle.
- Ungranted masters see ack_o=err_o=0 and wait.

## Timing
- Reset values:
  - FSM=IDLE, last_gnt=2, arb_gnt=2.
  - All s_wb_* outputs 0, all ack/err 0.
  - tmo_evt=0, arb_busy=0, watchdog counter=0.
- Latency: request sampled at edge k gives s_wb_stb_o high from edge k+1. Master ack has the same cycle as s_wb_ack_i.
- At least one cycle with s_wb_stb_o low between consecutive transactions, because the SDRAM WB bridge requires stb to drop after ack. Minimum turnaround is 1 idle cycle.
- Minimum transaction with an immediate slave ack: request → stb (k+1) → ack (k+1) → stb low (k+2) → next grant stb (k+3).
- Watchdog: err_o asserts in the cycle the counter equals cfg_tmo, i.e. cfg_tmo+1 cycles after stb rise. The counter saturates; it does not wrap.
- A change of cfg_arb_mode takes effect at the next IDLE arbitration only.
- Reset asserted mid-transaction: everything returns to reset values on that edge and s_wb_stb_o drops immediately. A late slave ack after reset is ignored.

## Test plan
- Single master: m0 write adr=0x100, dat=0xA5A5_5A5A, sel=0xF; slave acks after 4 cycles → s_wb_* match m0 inputs from k+1; m0 ack on the same cycle; stb low for 1 cycle after.
- Round-robin fairness: all three masters requesting continuously, 9 transactions → grant order 0,1,2,0,1,2,0,1,2; arb_gnt tracks the order.
- Fixed priority: cfg_arb_mode=1, m0 and m2 requesting → m0 always granted while requesting; m2 is granted only after m0 deasserts.
- Abandon: m1 read granted, m1 drops cyc at cycle 2, slave acks at cycle 5 → FSM in DRAIN, no ack to any master, IDLE at cycle 6, next request served normally.
- Watchdog: cfg_tmo=10, slave never acks → m2_wb_err_o and tmo_evt pulse 11 cycles after stb rise; stb drops next cycle. With cfg_tmo=0 no error after 2000 cycles.
- Reset mid-transaction: wb_rst_i high during BUSY → all outputs 0 on the next edge; after reset, a late s_wb_ack_i produces no master ack; first grant after reset goes to m0.
